// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the stage sequencer: opcode constants, state
// encoding, opcode class, strobe payload and the opcode classifier.
package stage_sequencer_pkg;

  localparam int unsigned STATE_W   = 4;
  localparam int unsigned IR_W      = 32;
  localparam int unsigned INSTRET_W = 32;
  localparam int unsigned OPC_W     = 7;

  // RV32 base opcodes the core supports
  localparam logic [OPC_W-1:0] DECODE_R_TYPE   = 7'h33;
  localparam logic [OPC_W-1:0] DECODE_I_TYPE   = 7'h13;
  localparam logic [OPC_W-1:0] DECODE_L_TYPE   = 7'h03;
  localparam logic [OPC_W-1:0] DECODE_S_TYPE   = 7'h23;
  localparam logic [OPC_W-1:0] DECODE_B_TYPE   = 7'h63;
  localparam logic [OPC_W-1:0] DECODE_U_TYPE   = 7'h37;
  localparam logic [OPC_W-1:0] DECODE_UPC_TYPE = 7'h17;

  typedef enum logic [STATE_W-1:0] {
    STATE_IDLE    = 4'd0,
    STATE_FETCH   = 4'd1,
    STATE_LOAD_IR = 4'd2,
    STATE_DECODE  = 4'd3,
    STATE_EXEC    = 4'd4,
    STATE_MEM     = 4'd5,
    STATE_WRITE   = 4'd6,
    STATE_RFWR    = 4'd7,
    STATE_PCUPD   = 4'd8,
    STATE_HALT    = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_L   = 3'd2,
    CLS_S   = 3'd3,
    CLS_B   = 3'd4,
    CLS_U   = 3'd5,
    CLS_UPC = 3'd6,
    CLS_BAD = 3'd7
  } op_class_e;

  // One-cycle stage qualification strobes driven to the datapath
  typedef struct packed {
    logic if_req;
    logic ir_load;
    logic dec_q;
    logic ex_q;
    logic dmem_req;
    logic dmem_we;
    logic wd_q;
    logic rf_we;
    logic pc_q;
  } strobes_t;

  // Map a 7-bit opcode onto its instruction class
  function automatic op_class_e decode_class(input logic [OPC_W-1:0] opcode);
    op_class_e cls;
    case (opcode)
      DECODE_R_TYPE:   cls = CLS_R;
      DECODE_I_TYPE:   cls = CLS_I;
      DECODE_L_TYPE:   cls = CLS_L;
      DECODE_S_TYPE:   cls = CLS_S;
      DECODE_B_TYPE:   cls = CLS_B;
      DECODE_U_TYPE:   cls = CLS_U;
      DECODE_UPC_TYPE: cls = CLS_UPC;
      default:         cls = CLS_BAD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Sequencer <-> datapath/memory bundle.
//   master: sequencer side (consumes run/IR/acks, drives strobes and status)
//   slave : datapath/memory side
interface stage_sequencer_if;
  import stage_sequencer_pkg::*;

  logic                 run_i;
  logic [IR_W-1:0]      ir_i;
  logic                 imem_ack_i;
  logic                 dmem_ack_i;
  logic                 if_req_o;
  logic                 ir_load_o;
  logic                 dec_q_o;
  logic                 ex_q_o;
  logic                 dmem_req_o;
  logic                 dmem_we_o;
  logic                 wd_q_o;
  logic                 rf_we_o;
  logic                 pc_q_o;
  logic [STATE_W-1:0]   state_o;
  logic                 illegal_o;
  logic                 timeout_o;
  logic [INSTRET_W-1:0] instret_o;

  modport master (
    input  run_i, ir_i, imem_ack_i, dmem_ack_i,
    output if_req_o, ir_load_o, dec_q_o, ex_q_o, dmem_req_o, dmem_we_o,
           wd_q_o, rf_we_o, pc_q_o, state_o, illegal_o, timeout_o, instret_o
  );

  modport slave (
    output run_i, ir_i, imem_ack_i, dmem_ack_i,
    input  if_req_o, ir_load_o, dec_q_o, ex_q_o, dmem_req_o, dmem_we_o,
           wd_q_o, rf_we_o, pc_q_o, state_o, illegal_o, timeout_o, instret_o
  );
endinterface

// File: rtl/stage_sequencer_wait_counter.sv
// Memory-ack wait counter shared by FETCH and MEM.
// Ports: clk, reset (async active-low), clr (restart at 0), en (count one
// wait cycle), expired_c (counter has reached MEM_TIMEOUT-1).
module stage_sequencer_wait_counter #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at the last wait cycle so it can never wrap back to 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_c = (cnt_q == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer. Steps one instruction at a time
// through fetch, IR load, decode, execute, memory, writeback latch, RF write
// and PC update, pulsing one registered strobe per visited state.
// Ports: clk, reset (async active-low), bus (stage_sequencer_if.master:
// run/IR/ack inputs, stage strobes, debug state, sticky illegal/timeout flags,
// retired-instruction count).
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  stage_sequencer_if.master         bus
);

  state_e               state_q, state_d;
  strobes_t             strobes_q, strobes_d;
  op_class_e            cls_q;
  logic                 rd_zero_q;
  logic                 illegal_q, timeout_q;
  logic [INSTRET_W-1:0] instret_q;
  logic                 illegal_set, timeout_set;
  logic                 wait_clr, wait_en, wait_expired_c;
  logic                 unused_ir_bits;

  assign unused_ir_bits = ^bus.ir_i[IR_W-1:12];

  // Restart the wait count on every entry into a memory wait state
  assign wait_clr = (state_d != state_q) &&
                    ((state_d == STATE_FETCH) || (state_d == STATE_MEM));
  assign wait_en  = (state_q == STATE_FETCH) || (state_q == STATE_MEM);

  stage_sequencer_wait_counter #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait (
    .clk       (clk),
    .reset     (reset),
    .clr       (wait_clr),
    .en        (wait_en),
    .expired_c (wait_expired_c)
  );

  // Next state, flag set conditions, and strobes decoded from the next state
  // so the registered strobes line up with the registered state
  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    timeout_set = 1'b0;
    strobes_d   = '0;

    case (state_q)
      STATE_IDLE:    if (bus.run_i) state_d = STATE_FETCH;
      STATE_FETCH: begin
        if (bus.imem_ack_i) begin
          state_d = STATE_LOAD_IR;
        end else if (wait_expired_c) begin
          state_d     = STATE_HALT;
          timeout_set = 1'b1;
        end
      end
      STATE_LOAD_IR: state_d = STATE_DECODE;
      STATE_DECODE: begin
        if (decode_class(bus.ir_i[OPC_W-1:0]) == CLS_BAD) begin
          state_d     = STATE_HALT;
          illegal_set = 1'b1;
        end else begin
          state_d = STATE_EXEC;
        end
      end
      STATE_EXEC: begin
        case (cls_q)
          CLS_L, CLS_S: state_d = STATE_MEM;
          CLS_B:        state_d = STATE_PCUPD;
          default:      state_d = STATE_WRITE;
        endcase
      end
      STATE_MEM: begin
        if (bus.dmem_ack_i) begin
          state_d = (cls_q == CLS_S) ? STATE_PCUPD : STATE_WRITE;
        end else if (wait_expired_c) begin
          state_d     = STATE_HALT;
          timeout_set = 1'b1;
        end
      end
      STATE_WRITE:   state_d = STATE_RFWR;
      STATE_RFWR:    state_d = STATE_PCUPD;
      STATE_PCUPD:   state_d = bus.run_i ? STATE_FETCH : STATE_IDLE;
      STATE_HALT:    state_d = STATE_HALT;
      default:       state_d = STATE_IDLE;
    endcase

    case (state_d)
      STATE_FETCH:   strobes_d.if_req  = 1'b1;
      STATE_LOAD_IR: strobes_d.ir_load = 1'b1;
      STATE_DECODE:  strobes_d.dec_q   = 1'b1;
      STATE_EXEC:    strobes_d.ex_q    = 1'b1;
      STATE_MEM: begin
        strobes_d.dmem_req = 1'b1;
        strobes_d.dmem_we  = (cls_q == CLS_S);
      end
      STATE_WRITE:   strobes_d.wd_q    = 1'b1;
      STATE_RFWR:    strobes_d.rf_we   = !rd_zero_q;
      STATE_PCUPD:   strobes_d.pc_q    = 1'b1;
      default:       strobes_d         = '0;
    endcase
  end

  // State, strobes, latched decode info and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= STATE_IDLE;
      strobes_q <= '0;
      cls_q     <= CLS_R;
      rd_zero_q <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      strobes_q <= strobes_d;
      if (state_q == STATE_DECODE) begin
        cls_q     <= decode_class(bus.ir_i[OPC_W-1:0]);
        rd_zero_q <= (bus.ir_i[11:7] == 5'd0);
      end
      if (illegal_set) illegal_q <= 1'b1;
      if (timeout_set) timeout_q <= 1'b1;
      if (state_q == STATE_PCUPD) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  assign bus.if_req_o   = strobes_q.if_req;
  assign bus.ir_load_o  = strobes_q.ir_load;
  assign bus.dec_q_o    = strobes_q.dec_q;
  assign bus.ex_q_o     = strobes_q.ex_q;
  assign bus.dmem_req_o = strobes_q.dmem_req;
  assign bus.dmem_we_o  = strobes_q.dmem_we;
  assign bus.wd_q_o     = strobes_q.wd_q;
  assign bus.rf_we_o    = strobes_q.rf_we;
  assign bus.pc_q_o     = strobes_q.pc_q;
  assign bus.state_o    = state_q;
  assign bus.illegal_o  = illegal_q;
  assign bus.timeout_o  = timeout_q;
  assign bus.instret_o  = instret_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: a reference model expands each issued
// instruction into its expected per-cycle strobe pattern; a monitor pops and
// compares one pattern for every cycle the sequencer is busy.
module tb_stage_sequencer;
  import stage_sequencer_pkg::*;

  localparam int unsigned TO = 4;

  // strobe vector bit positions
  localparam logic [8:0] V_IF   = 9'h100;
  localparam logic [8:0] V_IRL  = 9'h080;
  localparam logic [8:0] V_DEC  = 9'h040;
  localparam logic [8:0] V_EX   = 9'h020;
  localparam logic [8:0] V_MREQ = 9'h010;
  localparam logic [8:0] V_MWE  = 9'h008;
  localparam logic [8:0] V_WD   = 9'h004;
  localparam logic [8:0] V_RF   = 9'h002;
  localparam logic [8:0] V_PC   = 9'h001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  stage_sequencer_if bus();

  stage_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         exp_instret = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;
  logic [6:0] legal_opc [0:6];

  function automatic logic [8:0] strobes_now();
    return {bus.if_req_o, bus.ir_load_o, bus.dec_q_o, bus.ex_q_o, bus.dmem_req_o,
            bus.dmem_we_o, bus.wd_q_o, bus.rf_we_o, bus.pc_q_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expand an instruction into its cycle-by-cycle strobes.
  // outcome: 0 retires, 1 illegal halt, 2 timeout halt.
  task automatic model(input logic [31:0] ir, input int fd, input int md, output int outcome);
    int kind;
    case (ir[6:0])
      7'h33, 7'h13, 7'h37, 7'h17: kind = 0;
      7'h03:                      kind = 1;
      7'h23:                      kind = 2;
      7'h63:                      kind = 3;
      default:                    kind = -1;
    endcase
    for (int i = 0; i < ((fd < int'(TO)) ? fd + 1 : int'(TO)); i++) exp_q.push_back(V_IF);
    if (fd >= int'(TO)) begin outcome = 2; return; end
    exp_q.push_back(V_IRL);
    exp_q.push_back(V_DEC);
    if (kind < 0) begin outcome = 1; return; end
    exp_q.push_back(V_EX);
    if (kind == 1 || kind == 2) begin
      for (int i = 0; i < ((md < int'(TO)) ? md + 1 : int'(TO)); i++)
        exp_q.push_back(V_MREQ | ((kind == 2) ? V_MWE : 9'h000));
      if (md >= int'(TO)) begin outcome = 2; return; end
    end
    if (kind == 0 || kind == 1) begin
      exp_q.push_back(V_WD);
      exp_q.push_back((ir[11:7] != 5'd0) ? V_RF : 9'h000);
    end
    exp_q.push_back(V_PC);
    outcome = 0;
  endtask

  // Monitor: one expected pattern per busy cycle
  initial begin
    forever begin
      @(negedge clk);
      if (reset && bus.state_o != STATE_IDLE && bus.state_o != STATE_HALT) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_cycle: state %0d strobes %b, nothing expected",
                   bus.state_o, strobes_now());
        end else begin
          mon_exp = exp_q.pop_front();
          check("strobes", 32'(strobes_now()), 32'(mon_exp));
        end
      end
    end
  end

  // Memory/IR responder for one instruction; returns at PCUPD or HALT
  task automatic drive(input logic [31:0] ir, input int fd, input int md, input bit drop_run,
                       input bit abort_mem, output bit aborted);
    int fc = 0;
    int mc = 0;
    bit done = 0;
    aborted = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      if (abort_mem && bus.dmem_req_o) begin
        aborted = 1;
        done = 1;
      end else begin
        bus.imem_ack_i = bus.if_req_o && (fc == fd);
        if (bus.if_req_o) fc++;
        bus.dmem_ack_i = bus.dmem_req_o && (mc == md);
        if (bus.dmem_req_o) mc++;
        if (bus.ir_load_o) begin
          bus.ir_i = ir;
          if (drop_run) bus.run_i = 1'b0;
        end
        if (bus.ex_q_o) bus.ir_i = $urandom;
        if (bus.pc_q_o || bus.state_o == STATE_HALT) done = 1;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drive_bound: instruction %08h did not finish, state %0d", ir, bus.state_o);
    end
  endtask

  task automatic run_instr(input logic [31:0] ir, input int fd, input int md, input bit drop_run,
                           output int outcome);
    bit ab;
    model(ir, fd, md, outcome);
    bus.run_i = 1'b1;
    drive(ir, fd, md, drop_run, 1'b0, ab);
    if (outcome == 0) exp_instret++;
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    check({name, "_idle"}, 32'(bus.state_o), 32'(STATE_IDLE));
    check({name, "_instret"}, bus.instret_o, 32'(exp_instret));
  endtask

  task automatic halt_check(input string name, input bit ill, input bit tmo);
    check({name, "_illegal"}, 32'(bus.illegal_o), 32'(ill));
    check({name, "_timeout"}, 32'(bus.timeout_o), 32'(tmo));
    repeat (3) @(negedge clk);
    check({name, "_held"}, 32'(bus.state_o), 32'(STATE_HALT));
    check({name, "_quiet"}, 32'(strobes_now()), 32'd0);
    check({name, "_instret"}, bus.instret_o, 32'(exp_instret));
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.run_i = 1'b0;
    bus.imem_ack_i = 1'b0;
    bus.dmem_ack_i = 1'b0;
    exp_q.delete();
    exp_instret = 0;
    @(negedge clk);
    check("reset_instret", bus.instret_o, 32'd0);
    check("reset_flags", 32'({bus.illegal_o, bus.timeout_o}), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  oc;
    bit  ab;
    logic [31:0] ir;
    legal_opc[0] = 7'h33; legal_opc[1] = 7'h13; legal_opc[2] = 7'h03; legal_opc[3] = 7'h23;
    legal_opc[4] = 7'h63; legal_opc[5] = 7'h37; legal_opc[6] = 7'h17;
    bus.run_i = 1'b0; bus.ir_i = '0; bus.imem_ack_i = 1'b0; bus.dmem_ack_i = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_state", 32'(bus.state_o), 32'(STATE_IDLE));
    check("rst_strobes", 32'(strobes_now()), 32'd0);
    check("rst_instret", bus.instret_o, 32'd0);
    check("rst_flags", 32'({bus.illegal_o, bus.timeout_o}), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_instr(32'h002081B3, 0, 0, 1'b1, oc); idle_check("r_type");
    run_instr(32'h0000A103, 0, 3, 1'b1, oc); idle_check("load_wait3");
    run_instr(32'h0020A023, 0, 0, 1'b0, oc);
    run_instr(32'h00208463, 0, 0, 1'b1, oc); idle_check("store_branch");
    run_instr(32'h00100013, 0, 0, 1'b1, oc); idle_check("addi_x0");
    run_instr(32'h002081B3, 3, 0, 1'b1, oc); idle_check("fetch_ack_last");

    for (int n = 0; n < 30; n++) begin
      ir = $urandom;
      ir[6:0] = legal_opc[$urandom_range(0, 6)];
      if ($urandom_range(0, 3) == 0) ir[11:7] = 5'd0;
      run_instr(ir, int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)),
                (n == 29) || ($urandom_range(0, 3) == 0), oc);
      if (!bus.run_i) idle_check("random");
    end

    run_instr(32'h0000007F, 0, 0, 1'b0, oc); halt_check("illegal", 1'b1, 1'b0);
    do_reset();
    run_instr(32'h002081B3, 99, 0, 1'b0, oc); halt_check("fetch_timeout", 1'b0, 1'b1);
    do_reset();
    run_instr(32'h0000A103, 1, 99, 1'b0, oc); halt_check("mem_timeout", 1'b0, 1'b1);
    do_reset();

    // async reset in the middle of a load's MEM phase
    run_instr(32'h002081B3, 0, 0, 1'b0, oc);
    model(32'h0000A103, 0, 3, oc);
    drive(32'h0000A103, 0, 3, 1'b0, 1'b1, ab);
    check("abort_reached_mem", 32'(ab), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("abort_state", 32'(bus.state_o), 32'(STATE_IDLE));
    check("abort_strobes", 32'(strobes_now()), 32'd0);
    check("abort_instret", bus.instret_o, 32'd0);
    exp_q.delete();
    exp_instret = 0;
    @(negedge clk);
    model(32'h002081B3, 0, 0, oc);
    reset = 1'b1;
    @(posedge clk);
    #1 check("release_fetch", 32'(bus.state_o), 32'(STATE_FETCH));
    drive(32'h002081B3, 0, 0, 1'b1, 1'b0, ab);
    exp_instret++;
    idle_check("after_abort");

    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Multi-cycle control FSM for the core. It issues one-cycle qualification strobes that step an instruction through fetch, IR load, decode, execute, memory, writeback latch, register-file write and PC update. It drives the writeback stage's latch strobe (wd_q_o) and the PC-update strobe, and handshakes with instruction and data memory. Per-state strobes mean each datapath stage latches exactly once per instruction.

Parameters:
MEM_TIMEOUT, 255, maximum number of cycles spent in FETCH or MEM waiting for an ack before halting (≥2).
CNT_W, 8, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
run_i  in  1  enable; when low, the sequencer parks in IDLE after the current instruction retires
ir_i  in  32  instruction register contents; sampled only in DECODE
imem_ack_i  in  1  instruction memory ack; IR data is valid on the following cycle
dmem_ack_i  in  1  data memory ack
if_req_o  out  1  instruction fetch request, level (FETCH state)
ir_load_o  out  1  IR latch strobe
dec_q_o  out  1  decode latch strobe
ex_q_o  out  1  execute latch strobe
dmem_req_o  out  1  data memory request, level (MEM state)
dmem_we_o  out  1  data memory write; only high together with dmem_req_o for S-type
wd_q_o  out  1  writeback-stage latch strobe
rf_we_o  out  1  register-file write enable
pc_q_o  out  1  PC update strobe (loads the writeback stage's next-PC)
state_o  out  4  current state encoding (debug)
illegal_o  out  1  sticky: unknown opcode decoded
timeout_o  out  1  sticky: memory ack timeout
instret_o  out  32  retired-instruction count

Behaviour:
- Reset (reset=0, async): state=IDLE; all strobes 0; illegal_o=0, timeout_o=0, instret_o=0; internal class/rd registers cleared. Reset asserted mid-instruction aborts the instruction with no partial PC update.
- Outputs are Moore, decoded from the registered state. Every strobe is high for exactly one cycle per visit to its state.
- IDLE: run_i=1 -> FETCH.
- FETCH: if_req_o=1; wait counter cleared on entry.
  - imem_ack_i=1 -> LOAD_IR.
  - No ack and counter=MEM_TIMEOUT-1 -> HALT, timeout_o=1.
  - Ack in the same cycle as the timeout: ack wins.
- LOAD_IR: ir_load_o=1 -> DECODE.
- DECODE: dec_q_o=1. Latch the opcode class from ir_i[6:0] and the rd==0 flag from ir_i[11:7] into internal registers; later states use only these latched values, so ir_i may change after DECODE.
  - Legal opcodes: R, I, L, S, B, U, UPC -> EXEC.
  - Any other opcode -> HALT, illegal_o=1.
- EXEC: ex_q_o=1.
  - L or S -> MEM.
  - B -> PCUPD.
  - R, I, U, UPC -> WRITE.
- MEM: dmem_req_o=1; dmem_we_o=1 for S only. Counter rules are identical to FETCH.
  - Ack with L -> WRITE.
  - Ack with S -> PCUPD.
- WRITE: wd_q_o=1 -> RFWR.
- RFWR: rf_we_o=1 unless the latched rd==0 (then 0) -> PCUPD.
- PCUPD: pc_q_o=1; instret_o increments (wraps 0xFFFFFFFF -> 0).
  - run_i=1 -> FETCH; run_i=0 -> IDLE.
- run_i deasserted mid-instruction has no effect until PCUPD.
- HALT: all strobes 0; state held until reset.
- Latency with ack in the first wait cycle (cycles from FETCH entry through PCUPD inclusive): R/I/U/UPC=7, L=8, S=6, B=5. Each extra wait cycle adds 1.
- Wait counter saturates and never wraps. The state register has no unreachable-state lockup: any undefined encoding -> IDLE.

Decomposition:
- Shared header opcode.v: DECODE_R/I/L/S/B/U/UPC_TYPE constants (existing), plus new state-encoding constants STATE_IDLE..STATE_HALT (10 states, 4 bits).
- Sub-module: seq_wait_counter (clear, enable, MEM_TIMEOUT compare -> expired). It is shared by the FETCH and MEM states.

Test Plan:
- R-type 0x002081B3, imem_ack on the first FETCH cycle -> strobes in order if_req, ir_load, dec_q, ex_q, wd_q, rf_we, pc_q over exactly 7 cycles; instret_o=1.
- Load 0x0000A103, dmem_ack delayed 3 cycles -> dmem_req_o high for 4 cycles with dmem_we_o=0, then wd_q, rf_we, pc_q; total 11 cycles.
- Store 0x0020A023 then branch 0x00208463 -> store: dmem_we_o=1 during MEM, no wd_q/rf_we; branch: 5 cycles, pc_q only, no wd_q; instret_o=2.
- ADDI to x0 (0x00100013) -> wd_q_o pulses, rf_we_o stays 0, pc_q_o pulses.
- Opcode 0x7F -> HALT after DECODE, illegal_o=1, no further strobes. With MEM_TIMEOUT=4 and imem_ack never asserted -> timeout_o=1 after 4 FETCH cycles. Ack on the 4th cycle -> no timeout.
- Reset pulled low during MEM with run_i=1 -> state_o=IDLE asynchronously, all outputs 0, instret_o=0. Reset release -> FETCH on the next cycle.
